// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the memory responder: loader FSM states,
// byte/count widths and the "loader is accepting bytes" decode.
package mem_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_HDR_HI = 3'd3,
    ST_DATA   = 3'd4
  } state_t;

  function automatic logic loader_ready(state_t s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side memory ports plus the host boot-loader byte link.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] ram_data;
  logic              ld_start;
  logic              ld_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_ready;
  logic              cpu_hold;
  logic              ld_done;
  logic              ld_err;

  modport slave (
    input  inst_addr, mem_we, mem_addr, mem_data, ld_start, ld_valid, ld_byte,
    output inst, ram_data, ld_ready, cpu_hold, ld_done, ld_err
  );

  modport master (
    output inst_addr, mem_we, mem_addr, mem_data, ld_start, ld_valid, ld_byte,
    input  inst, ram_data, ld_ready, cpu_hold, ld_done, ld_err
  );
endinterface

// File: rtl/mem_responder_sp_ram.sv
// Word RAM with asynchronous read and synchronous write; addresses at or
// beyond DEPTH read as zero and never write.
module sp_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/mem_responder.sv
// Instruction/data memory responder with a byte-stream boot loader that
// fills IMEM and holds the core in reset while loading.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int BOOT_HOLD  = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam logic [CNT_W:0] IMEM_DEPTH_W = IMEM_DEPTH[CNT_W:0];

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         waddr_q, waddr_d;
  logic [1:0]               bidx_q, bidx_d;
  logic [DATA_W-BYTE_W-1:0] asm_q, asm_d;
  logic                     ld_err_q, ld_err_d;
  logic                     ld_done_q, ld_done_d;
  logic                     cpu_hold_q;
  logic                     ld_ready;
  logic                     xfer;
  logic                     imem_we;
  logic [DATA_W-1:0]        imem_wdata;
  logic [CNT_W-1:0]         hdr_cnt;

  assign ld_ready   = loader_ready(state_q);
  assign xfer       = bus.ld_valid && ld_ready;
  assign hdr_cnt    = {bus.ld_byte, cnt_q[BYTE_W-1:0]};
  // The final byte goes straight into the top lane; only three are buffered.
  assign imem_wdata = {bus.ld_byte, asm_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    waddr_d   = waddr_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    ld_err_d  = ld_err_q;
    ld_done_d = 1'b0;
    imem_we   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (bus.ld_start) begin
          state_d  = ST_HDR_LO;
          ld_err_d = 1'b0;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          cnt_d   = {cnt_q[CNT_W-1:BYTE_W], bus.ld_byte};
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (xfer) begin
          cnt_d = hdr_cnt;
          if ({1'b0, hdr_cnt} > IMEM_DEPTH_W) begin
            ld_err_d = 1'b1;
          end
          if (hdr_cnt == '0) begin
            state_d   = ST_RUN;
            ld_done_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            waddr_d = '0;
            bidx_d  = '0;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (bidx_q == 2'd3) begin
            // Oversized loads keep consuming words so the stream stays aligned.
            imem_we = ({1'b0, waddr_q} < IMEM_DEPTH_W);
            waddr_d = waddr_q + 1'b1;
            bidx_d  = '0;
            if (waddr_q + 1'b1 == cnt_q) begin
              state_d   = ST_RUN;
              ld_done_d = 1'b1;
            end
          end else begin
            asm_d[{bidx_q, 3'b000} +: BYTE_W] = bus.ld_byte;
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= (BOOT_HOLD != 0) ? ST_IDLE : ST_RUN;
      cnt_q      <= '0;
      waddr_q    <= '0;
      bidx_q     <= '0;
      asm_q      <= '0;
      ld_err_q   <= 1'b0;
      ld_done_q  <= 1'b0;
      cpu_hold_q <= (BOOT_HOLD != 0);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      waddr_q    <= waddr_d;
      bidx_q     <= bidx_d;
      asm_q      <= asm_d;
      ld_err_q   <= ld_err_d;
      ld_done_q  <= ld_done_d;
      cpu_hold_q <= (state_d != ST_RUN);
    end
  end

  sp_ram #(.DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem (
    .clk     (clk),
    .we      (imem_we),
    .wr_addr (waddr_q[ADDR_W-1:0]),
    .wr_data (imem_wdata),
    .rd_addr (bus.inst_addr),
    .rd_data (bus.inst)
  );

  sp_ram #(.DEPTH(DMEM_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem (
    .clk     (clk),
    .we      (bus.mem_we && !cpu_hold_q),
    .wr_addr (bus.mem_addr),
    .wr_data (bus.mem_data),
    .rd_addr (bus.mem_addr),
    .rd_data (bus.ram_data)
  );

  assign bus.ld_ready = ld_ready;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.ld_err   = ld_err_q;

endmodule
